// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from several requesters into a single UART transmitter.
// Define UART_ARB_TIMEOUT_EN to add the err output and the tx_busy rise timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic [15:0]                 sent_cnt
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                        err
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic                r_tx_start;
  logic [DATA_W-1:0]   r_tx_data;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_active;
  logic [15:0]         r_sent_cnt;

  state_t              w_state_next;
  logic [NUM_REQ-1:0]  w_req_ready_next;
  logic                w_tx_start_next;
  logic [DATA_W-1:0]   w_tx_data_next;
  logic [ID_W-1:0]     w_grant_id_next;
  logic                w_active_next;
  logic [15:0]         w_sent_cnt_next;

  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  logic [DATA_W-1:0]   w_pick_data;
  int                  w_dist;
  int                  w_best_dist;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  logic                r_err;
  logic [TO_W-1:0]     r_to_cnt;
  logic                w_err_next;
  logic [TO_W-1:0]     w_to_cnt_next;
`endif

  // Pick the valid requester closest after the last grant, measured as (i - last - 1) mod NUM_REQ.
  always_comb begin
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_data = '0;
    w_dist      = 0;
    w_best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_grant_id)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_pick      = ID_W'(i);
        w_found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == ID_W'(i)) begin
        w_pick_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_req_ready_next = '0;
    w_tx_start_next  = 1'b0;
    w_tx_data_next   = r_tx_data;
    w_grant_id_next  = r_grant_id;
    w_sent_cnt_next  = r_sent_cnt;
`ifdef UART_ARB_TIMEOUT_EN
    w_err_next       = 1'b0;
    w_to_cnt_next    = r_to_cnt;
`endif
    case (r_state)
      IDLE: begin
        // A transmitter still busy from elsewhere blocks new grants.
        if (w_found && !tx_busy) begin
          w_req_ready_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
          w_tx_data_next   = w_pick_data;
          w_grant_id_next  = w_pick;
          w_state_next     = START;
        end
      end
      START: begin
        w_tx_start_next = 1'b1;
        w_state_next    = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_cnt_next   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_next = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
          w_err_next   = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_sent_cnt_next = r_sent_cnt + 16'd1;
          w_state_next    = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    w_active_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_grant_id  <= ID_W'(NUM_REQ - 1);
      r_active    <= 1'b0;
      r_sent_cnt  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_err       <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= w_req_ready_next;
      r_tx_start  <= w_tx_start_next;
      r_tx_data   <= w_tx_data_next;
      r_grant_id  <= w_grant_id_next;
      r_active    <= w_active_next;
      r_sent_cnt  <= w_sent_cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
      r_err       <= w_err_next;
      r_to_cnt    <= w_to_cnt_next;
`endif
    end
  end

  assign req_ready = r_req_ready;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign active    = r_active;
  assign sent_cnt  = r_sent_cnt;
`ifdef UART_ARB_TIMEOUT_EN
  assign err       = r_err;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple model transmitter.
// Timeout steps are built only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       tx_start;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_busy;
  logic [1:0]                 grant_id;
  logic                       active;
  logic [15:0]                sent_cnt;
`ifdef UART_ARB_TIMEOUT_EN
  logic                       err;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [15:0] expSent = 16'd0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .sent_cnt(sent_cnt)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*DATA_W-1:0] data);
    req_valid = valid;
    req_data  = data;
  endtask

  task automatic pushExp(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    checkOutput({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'd3);
    checkOutput({tag, "_active"}, 32'(active), 32'h0);
    checkOutput({tag, "_sent_cnt"}, 32'(sent_cnt), 32'h0);
`ifdef UART_ARB_TIMEOUT_EN
    checkOutput({tag, "_err"}, 32'(err), 32'h0);
`endif
  endtask

  // Waits for the next grant, checks it against the scoreboard and plays the transmitter.
  task automatic serveByte(input int busyCycles, input logic dropValid);
    exp_t e;
    int   waited;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("grant_seen", 32'(req_ready != '0), 32'h1);
    if (req_ready == '0) return;
    e = expQ.pop_front();
    checkOutput("req_ready", 32'(req_ready), 32'h1 << e.id);
    checkOutput("grant_id", 32'(grant_id), 32'(e.id));
    checkOutput("tx_data_grant", 32'(tx_data), 32'(e.data));
    checkOutput("tx_start_pre", 32'(tx_start), 32'h0);
    checkOutput("active_grant", 32'(active), 32'h1);
    if (dropValid) req_valid[e.id] = 1'b0;
    tick();
    checkOutput("req_ready_pulse", 32'(req_ready), 32'h0);
    checkOutput("tx_start", 32'(tx_start), 32'h1);
    tx_busy = 1'b1;
    tick();
    checkOutput("tx_start_once", 32'(tx_start), 32'h0);
    repeat (busyCycles) tick();
    checkOutput("tx_data_hold", 32'(tx_data), 32'(e.data));
    checkOutput("active_busy", 32'(active), 32'h1);
    tx_busy = 1'b0;
    tick();
    expSent = expSent + 16'd1;
    checkOutput("sent_cnt", 32'(sent_cnt), 32'(expSent));
    checkOutput("active_idle", 32'(active), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    tx_busy = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    repeat (2) tick();
    checkReset("reset");

    rst_n = 1'b1;
    tick();
    checkOutput("idle_no_req", 32'(req_ready), 32'h0);
    checkOutput("idle_inactive", 32'(active), 32'h0);

    $display("[TB] single requester");
    applyStimulus(4'b0001, 32'h0000_005A);
    pushExp(2'd0, 8'h5A);
    serveByte(2, 1'b1);

    $display("[TB] busy already high in IDLE");
    tx_busy = 1'b1;
    applyStimulus(4'b0010, 32'h0000_7700);
    repeat (3) tick();
    checkOutput("busy_block_ready", 32'(req_ready), 32'h0);
    checkOutput("busy_block_active", 32'(active), 32'h0);
    tx_busy = 1'b0;
    pushExp(2'd1, 8'h77);
    serveByte(1, 1'b1);

    $display("[TB] fairness");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expSent = 16'd0;
    applyStimulus(4'b1111, 32'hD3C2_B1A0);
    pushExp(2'd0, 8'hA0);
    pushExp(2'd1, 8'hB1);
    pushExp(2'd2, 8'hC2);
    pushExp(2'd3, 8'hD3);
    pushExp(2'd0, 8'hA0);
    for (int n = 0; n < 5; n++) serveByte(1, 1'b0);
    checkOutput("fair_sent5", 32'(sent_cnt), 32'd5);

    $display("[TB] wrap");
    applyStimulus(4'b1001, 32'hD3C2_B1A0);
    pushExp(2'd3, 8'hD3);
    serveByte(1, 1'b0);
    pushExp(2'd0, 8'hA0);
    serveByte(1, 1'b0);

    $display("[TB] reset mid-transfer");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expSent = 16'd0;
    applyStimulus(4'b0100, 32'hD3C2_B1A0);
    tick();
    checkOutput("mid_grant", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
    tick();
    tx_busy = 1'b1;
    repeat (2) tick();
    checkOutput("mid_in_flight", 32'(active), 32'h1);
    rst_n = 1'b0;
    tick();
    checkReset("mid_reset");
    rst_n = 1'b1;
    tx_busy = 1'b0;
    applyStimulus(4'b1111, 32'hD3C2_B1A0);
    pushExp(2'd0, 8'hA0);
    serveByte(1, 1'b0);
    req_valid = 4'b0000;
    tick();
    checkOutput("no_extra_ready", 32'(req_ready), 32'h0);

    $display("[TB] counter wrap");
    force dut.r_sent_cnt = 16'hFFFF;
    tick();
    release dut.r_sent_cnt;
    tick();
    checkOutput("cnt_forced", 32'(sent_cnt), 32'hFFFF);
    expSent = 16'hFFFF;
    applyStimulus(4'b0001, 32'h0000_0033);
    pushExp(2'd0, 8'h33);
    serveByte(1, 1'b1);
    checkOutput("cnt_wrapped", 32'(sent_cnt), 32'h0);

`ifdef UART_ARB_TIMEOUT_EN
    $display("[TB] busy timeout");
    applyStimulus(4'b0010, 32'h0000_6600);
    tick();
    checkOutput("to_grant", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    tick();
    checkOutput("to_tx_start", 32'(tx_start), 32'h1);
    repeat (15) tick();
    checkOutput("to_err_early", 32'(err), 32'h0);
    checkOutput("to_active_wait", 32'(active), 32'h1);
    tick();
    checkOutput("to_err_pulse", 32'(err), 32'h1);
    checkOutput("to_active_idle", 32'(active), 32'h0);
    checkOutput("to_sent_same", 32'(sent_cnt), 32'(expSent));
    tick();
    checkOutput("to_err_once", 32'(err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width; it matches the transmitter data width.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16, the number of cycles allowed for tx_busy to rise after tx_start.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  bit i high means requester i holds a byte.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  byte of requester i in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-cycle one-hot accept pulse to the granted requester.
REQ-009 SHALL have port tx_start  output  1  start strobe to the UART transmitter.
REQ-010 SHALL have port tx_data  output  DATA_W  byte presented to the transmitter.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the current or last-served requester.
REQ-013 SHALL have port active  output  1  high in every state except IDLE.
REQ-014 SHALL have port sent_cnt  output  16  count of completed bytes, wrapping from 0xFFFF to 0.

Function
REQ-015 SHALL implement the FSM states IDLE, START, WAIT_BUSY and WAIT_DONE, with all outputs registered.
REQ-016 In IDLE with any req_valid high, SHALL grant round-robin, searching from index (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 On grant, SHALL, in the same clock edge: pulse req_ready[g] for exactly one cycle, latch req_data[g] into tx_data, update grant_id to g, and enter START.
REQ-018 With no req_valid high, SHALL remain in IDLE with req_ready all zero.
REQ-019 In START, SHALL drive tx_start high for exactly one cycle, then enter WAIT_BUSY.
REQ-020 In WAIT_BUSY, SHALL enter WAIT_DONE on the first cycle tx_busy is sampled high.
REQ-021 In WAIT_DONE, SHALL hold tx_data stable, and on tx_busy sampled low SHALL increment sent_cnt and return to IDLE.
REQ-022 The next grant SHALL occur no earlier than the cycle after the return to IDLE, guaranteeing at least one idle cycle between tx_start pulses.
REQ-023 tx_data SHALL stay constant from the grant until the return to IDLE.
REQ-024 A requester dropping req_valid after acceptance SHALL NOT affect the byte in flight.
REQ-025 If tx_busy is already high in IDLE, SHALL NOT grant until tx_busy is low.
REQ-026 Changes to req_valid while not in IDLE SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-027 While rst_n is low at a clock edge, SHALL set: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=NUM_REQ-1 (so requester 0 wins first), active=0, sent_cnt=0, and the timeout counter and err to 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the byte without incrementing sent_cnt, and SHALL NOT emit any further req_ready pulse for it.

Configuration
REQ-029 With macro UART_ARB_TIMEOUT_EN defined, SHALL add output port err (1 bit) and a WAIT_BUSY cycle counter; if tx_busy stays low for BUSY_TIMEOUT cycles after tx_start, the block SHALL pulse err for one cycle, drop the byte, leave sent_cnt unchanged, and return to IDLE.
REQ-030 Without UART_ARB_TIMEOUT_EN, SHALL have no err port and no counter, and SHALL wait in WAIT_BUSY indefinitely.

Verification
REQ-031 Single requester: after reset, req_valid=0001 with data 0x5A -> req_ready=0001 for 1 cycle, tx_data=0x5A, tx_start pulses 1 cycle later; after the busy high/low sequence, sent_cnt=1.
REQ-032 Fairness: req_valid=1111 held, with a model transmitter -> grant order 0,1,2,3,0 and sent_cnt=5 after five bytes.
REQ-033 Wrap: with last grant=3, req_valid=1001 -> requester 0 is granted before 3; with last grant=0 -> requester 3 is granted.
REQ-034 Reset mid-transfer: rst_n low in WAIT_DONE -> next cycle all outputs are at reset values, sent_cnt is unchanged from 0, and the next grant goes to requester 0.
REQ-035 Timeout (UART_ARB_TIMEOUT_EN, BUSY_TIMEOUT=16): tx_busy held 0 -> err pulses 16 cycles after tx_start, the FSM returns to IDLE, and sent_cnt is unchanged.
REQ-036 Counter wrap: sent_cnt forced to 0xFFFF, then one completed byte -> sent_cnt=0x0000.
